// File: rtl/mdu_hilo_writer_pkg.sv
// mdu_hilo_writer_pkg: shared definitions for the HI/LO multiply/divide unit.
//   - MDU op encodings carried on the 3-bit op field
//   - controller state encoding (the MUL state is absent when MDU_FAST_MUL_EN is defined)
//   - divider iteration count
//   - magnitude/negate helpers shared by the multiplier and divider paths
package mdu_hilo_writer_pkg;

  localparam int unsigned MDU_DIV_ITERS = 32;

  typedef enum logic [2:0] {
    MDU_OP_MULT  = 3'b000,
    MDU_OP_MULTU = 3'b001,
    MDU_OP_DIV   = 3'b010,
    MDU_OP_DIVU  = 3'b011,
    MDU_OP_MTHI  = 3'b100,
    MDU_OP_MTLO  = 3'b101
  } mdu_op_e;

`ifdef MDU_FAST_MUL_EN
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DIV,
    ST_FIX
  } mdu_state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX
  } mdu_state_e;
`endif

  // Absolute value of a 32-bit operand when treated as signed.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (32'd0 - v) : v;
  endfunction

  function automatic logic [31:0] neg_if32(input logic [31:0] v, input logic n);
    return n ? (32'd0 - v) : v;
  endfunction

  function automatic logic [63:0] neg_if64(input logic [63:0] v, input logic n);
    return n ? (64'd0 - v) : v;
  endfunction

endpackage

// File: rtl/mdu_hilo_writer_if.sv
// mdu_hilo_writer_if: EX-stage <-> MDU request/result bundle.
//   master (EX stage): drives start, op, src_a, src_b, flush; observes busy and
//                      the HI/LO write strobes with data.
//   slave  (MDU):      the reverse.
interface mdu_hilo_writer_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        busy;
  logic        hi_we;
  logic [31:0] hi_o;
  logic        lo_we;
  logic [31:0] lo_o;

  modport master (
    output start, op, src_a, src_b, flush,
    input  busy, hi_we, hi_o, lo_we, lo_o
  );

  modport slave (
    input  start, op, src_a, src_b, flush,
    output busy, hi_we, hi_o, lo_we, lo_o
  );
endinterface

// File: rtl/mdu_hilo_writer_div_core.sv
// mdu_div_core: one unsigned restoring-division step (combinational).
//   rem_i  [32:0] partial remainder
//   dvs_i  [31:0] divisor magnitude
//   bit_i         next dividend bit, shifted into the remainder
//   rem_o  [32:0] new partial remainder
//   q_o           quotient bit produced by this step
module mdu_div_core (
  input  logic [32:0] rem_i,
  input  logic [31:0] dvs_i,
  input  logic        bit_i,
  output logic [32:0] rem_o,
  output logic        q_o
);
  logic [33:0] shifted;
  logic [32:0] diff;

  always_comb begin
    shifted = {rem_i, bit_i};
    q_o     = (shifted >= {2'b00, dvs_i});
    // Only consumed when q_o is set, where the true difference fits in 33 bits.
    diff    = shifted[32:0] - {1'b0, dvs_i};
    rem_o   = q_o ? diff : shifted[32:0];
  end
endmodule

// File: rtl/mdu_hilo_writer.sv
// mdu_hilo_writer: sole writer of the HI/LO register pair (EX stage).
//   clk, rst : clock; synchronous active-high reset
//   bus      : mdu_hilo_writer_if.slave
//              start/op/src_a/src_b/flush in; busy, hi_we/hi_o, lo_we/lo_o out
// Handles MULT/MULTU/DIV/DIVU/MTHI/MTLO. Divide is a 32-step restoring
// divider on magnitudes with sign fix-up in a final FIX cycle. Results leave as
// registered one-cycle write strobes; data holds between strobes.
// Build option: MDU_FAST_MUL_EN selects a single-cycle multiply instead of the
// 32-cycle shift-add MUL state.
module mdu_hilo_writer
  import mdu_hilo_writer_pkg::*;
#(
  parameter int unsigned DIV_ITERS = MDU_DIV_ITERS
) (
  input logic               clk,
  input logic               rst,
  mdu_hilo_writer_if.slave  bus
);

  localparam logic [4:0] LAST_CNT = 5'(DIV_ITERS - 1);

  mdu_state_e  state_q;
  logic [4:0]  cnt_q;
  logic        busy_q;
  logic        hi_we_q;
  logic        lo_we_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  logic [31:0] opa_q;     // dividend magnitude, quotient bits shift in at LSB; multiplicand for MUL
  logic [31:0] dvs_q;     // divisor magnitude
  logic [32:0] rem_q;     // partial remainder
  logic        neg_q_q;   // negate quotient / product
  logic        neg_r_q;   // remainder takes the dividend sign
  logic        dz_q;      // divide by zero

  mdu_op_e     op_e;
  logic        accept;
  logic        is_signed;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [32:0] rem_n;
  logic        q_bit;
  logic [31:0] quot_fix;
  logic [31:0] rem_fix;

  assign op_e      = mdu_op_e'(bus.op);
  assign accept    = bus.start & ~busy_q & ~bus.flush;
  assign is_signed = (op_e == MDU_OP_MULT) || (op_e == MDU_OP_DIV);
  assign a_mag     = mag32(bus.src_a, is_signed);
  assign b_mag     = mag32(bus.src_b, is_signed);

  mdu_div_core u_div_core (
    .rem_i (rem_q),
    .dvs_i (dvs_q),
    .bit_i (opa_q[31]),
    .rem_o (rem_n),
    .q_o   (q_bit)
  );

  // Restoring division on a zero divisor leaves all-ones quotient and |dividend|
  // as remainder; re-signing the remainder restores src_a exactly, so only the
  // quotient needs overriding.
  assign quot_fix = dz_q ? '1 : neg_if32(opa_q, neg_q_q);
  assign rem_fix  = neg_if32(rem_q[31:0], neg_r_q);

`ifdef MDU_FAST_MUL_EN
  logic signed [63:0] fa;
  logic signed [63:0] fb;
  logic        [63:0] fast_prod;

  // 33-bit operands (sign bit only for MULT) extended to 64; low 64 bits of
  // the product equal the 33x33 result.
  always_comb begin
    fa        = {{31{is_signed & bus.src_a[31]}}, is_signed & bus.src_a[31], bus.src_a};
    fb        = {{31{is_signed & bus.src_b[31]}}, is_signed & bus.src_b[31], bus.src_b};
    fast_prod = 64'(fa * fb);
  end
`else
  // acc_q[63:32] accumulates, acc_q[31:0] starts as the multiplier and is
  // consumed LSB first as the sum shifts right.
  logic [63:0] acc_q;
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [63:0] mul_res;

  always_comb begin
    mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opa_q} : 33'd0);
    mul_next = {mul_sum, acc_q[31:1]};
    mul_res  = neg_if64(mul_next, neg_q_q);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      hi_we_q <= 1'b0;
      lo_we_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      opa_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      dz_q    <= 1'b0;
`ifndef MDU_FAST_MUL_EN
      acc_q   <= '0;
`endif
    end else begin
      hi_we_q <= 1'b0;
      lo_we_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            case (op_e)
              MDU_OP_MTHI: begin
                hi_q    <= bus.src_a;
                hi_we_q <= 1'b1;
              end
              MDU_OP_MTLO: begin
                lo_q    <= bus.src_a;
                lo_we_q <= 1'b1;
              end
              MDU_OP_MULT, MDU_OP_MULTU: begin
`ifdef MDU_FAST_MUL_EN
                hi_q    <= fast_prod[63:32];
                lo_q    <= fast_prod[31:0];
                hi_we_q <= 1'b1;
                lo_we_q <= 1'b1;
`else
                opa_q   <= a_mag;
                acc_q   <= {32'd0, b_mag};
                neg_q_q <= is_signed & (bus.src_a[31] ^ bus.src_b[31]);
                cnt_q   <= '0;
                busy_q  <= 1'b1;
                state_q <= ST_MUL;
`endif
              end
              MDU_OP_DIV, MDU_OP_DIVU: begin
                opa_q   <= a_mag;
                dvs_q   <= b_mag;
                rem_q   <= '0;
                neg_q_q <= is_signed & (bus.src_a[31] ^ bus.src_b[31]);
                neg_r_q <= is_signed & bus.src_a[31];
                dz_q    <= (bus.src_b == 32'd0);
                cnt_q   <= '0;
                busy_q  <= 1'b1;
                state_q <= ST_DIV;
              end
              default: ;
            endcase
          end
        end
`ifndef MDU_FAST_MUL_EN
        ST_MUL: begin
          if (bus.flush) begin
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            acc_q <= mul_next;
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == LAST_CNT) begin
              hi_q    <= mul_res[63:32];
              lo_q    <= mul_res[31:0];
              hi_we_q <= 1'b1;
              lo_we_q <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end
          end
        end
`endif
        ST_DIV: begin
          if (bus.flush) begin
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            rem_q <= rem_n;
            opa_q <= {opa_q[30:0], q_bit};
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == LAST_CNT) begin
              state_q <= ST_FIX;
            end
          end
        end
        ST_FIX: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
          if (!bus.flush) begin
            hi_q    <= rem_fix;
            lo_q    <= quot_fix;
            hi_we_q <= 1'b1;
            lo_we_q <= 1'b1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.hi_we = hi_we_q;
  assign bus.hi_o  = hi_q;
  assign bus.lo_we = lo_we_q;
  assign bus.lo_o  = lo_q;

endmodule

// File: tb/tb_mdu_hilo_writer.sv
// tb_mdu_hilo_writer: directed self-checking bench for mdu_hilo_writer.
// Honours MDU_FAST_MUL_EN for the expected multiply latency.
module tb_mdu_hilo_writer;
  import mdu_hilo_writer_pkg::*;

`ifdef MDU_FAST_MUL_EN
  localparam int unsigned MUL_LAT  = 1;
  localparam int unsigned MUL_BUSY = 0;
`else
  localparam int unsigned MUL_LAT  = 33;
  localparam int unsigned MUL_BUSY = 32;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mdu_hilo_writer_if bus();

  mdu_hilo_writer #(.DIV_ITERS(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned hi_strb = 0;
  int unsigned lo_strb = 0;

  always @(negedge clk) begin
    if (bus.hi_we === 1'b1) hi_strb++;
    if (bus.lo_we === 1'b1) lo_strb++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input int unsigned exp_lat,
                        input int unsigned exp_busy);
    int unsigned cyc;
    int unsigned bcnt;
    bus.start = 1'b1;
    bus.op    = op;
    bus.src_a = a;
    bus.src_b = b;
    tick();
    bus.start = 1'b0;
    cyc  = 1;
    bcnt = 0;
    while (bus.hi_we !== 1'b1 && cyc < 100) begin
      if (bus.busy === 1'b1) bcnt++;
      tick();
      cyc++;
    end
    check({tag, ".lat"},   cyc,  exp_lat);
    check({tag, ".busyn"}, bcnt, exp_busy);
    check({tag, ".busy0"}, {31'd0, bus.busy},  32'd0);
    check({tag, ".lo_we"}, {31'd0, bus.lo_we}, 32'd1);
    check({tag, ".hi"},    bus.hi_o, exp_hi);
    check({tag, ".lo"},    bus.lo_o, exp_lo);
    tick();
    check({tag, ".we_off"}, {30'd0, bus.hi_we, bus.lo_we}, 32'd0);
  endtask

  int unsigned h0;
  int unsigned l0;

  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = 3'b000;
    bus.src_a = '0;
    bus.src_b = '0;
    bus.flush = 1'b0;
    tick();
    tick();
    check("rst.busy", {31'd0, bus.busy}, 32'd0);
    check("rst.we",   {30'd0, bus.hi_we, bus.lo_we}, 32'd0);
    check("rst.hi",   bus.hi_o, 32'd0);
    check("rst.lo",   bus.lo_o, 32'd0);
    rst = 1'b0;
    tick();

    // MTHI then MTLO back to back
    bus.start = 1'b1; bus.op = MDU_OP_MTHI; bus.src_a = 32'h12345678;
    tick();
    check("mthi.hi_we", {31'd0, bus.hi_we}, 32'd1);
    check("mthi.hi",    bus.hi_o, 32'h12345678);
    check("mthi.lo_we", {31'd0, bus.lo_we}, 32'd0);
    check("mthi.busy",  {31'd0, bus.busy},  32'd0);
    bus.op = MDU_OP_MTLO; bus.src_a = 32'hCAFEF00D;
    tick();
    bus.start = 1'b0;
    check("mtlo.hi_we", {31'd0, bus.hi_we}, 32'd0);
    check("mtlo.lo_we", {31'd0, bus.lo_we}, 32'd1);
    check("mtlo.lo",    bus.lo_o, 32'hCAFEF00D);
    tick();
    check("hold.we", {30'd0, bus.hi_we, bus.lo_we}, 32'd0);
    check("hold.hi", bus.hi_o, 32'h12345678);
    check("hold.lo", bus.lo_o, 32'hCAFEF00D);

    run_op("mult",  MDU_OP_MULT,  32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT, MUL_BUSY);
    run_op("multu", MDU_OP_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, MUL_LAT, MUL_BUSY);
    run_op("mult2", MDU_OP_MULT,  32'hFFFFFFFD, 32'hFFFFFFF9, 32'h00000000, 32'h00000015, MUL_LAT, MUL_BUSY);
    run_op("div",   MDU_OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 34, 33);
    run_op("divu",  MDU_OP_DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E, 34, 33);
    run_op("divu0", MDU_OP_DIVU,  32'd5,        32'd0,        32'h00000005, 32'hFFFFFFFF, 34, 33);
    run_op("div0",  MDU_OP_DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 34, 33);
    run_op("divmin",MDU_OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 34, 33);

    // Flush in cycle 10 of a DIV, then MTLO in cycle 11
    h0 = hi_strb; l0 = lo_strb;
    bus.start = 1'b1; bus.op = MDU_OP_DIV; bus.src_a = 32'hFFFFFFF9; bus.src_b = 32'd2;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("flush.busy", {31'd0, bus.busy}, 32'd0);
    bus.start = 1'b1; bus.op = MDU_OP_MTLO; bus.src_a = 32'hA5A5A5A5;
    tick();
    bus.start = 1'b0;
    check("flush.lo_we", {31'd0, bus.lo_we}, 32'd1);
    check("flush.lo",    bus.lo_o, 32'hA5A5A5A5);
    check("flush.hi_we", {31'd0, bus.hi_we}, 32'd0);
    repeat (40) tick();
    check("flush.nhi", hi_strb - h0, 32'd0);
    check("flush.nlo", lo_strb - l0, 32'd1);

    // Reset in cycle 20 of a DIV
    h0 = hi_strb; l0 = lo_strb;
    bus.start = 1'b1; bus.op = MDU_OP_DIVU; bus.src_a = 32'd100; bus.src_b = 32'd7;
    tick();
    bus.start = 1'b0;
    repeat (19) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst.busy", {31'd0, bus.busy}, 32'd0);
    check("mrst.we",   {30'd0, bus.hi_we, bus.lo_we}, 32'd0);
    check("mrst.hi",   bus.hi_o, 32'd0);
    check("mrst.lo",   bus.lo_o, 32'd0);
    repeat (40) tick();
    check("mrst.nstrb", (hi_strb - h0) + (lo_strb - l0), 32'd0);

    // start held through busy: exactly one result
    h0 = hi_strb; l0 = lo_strb;
    bus.start = 1'b1; bus.op = MDU_OP_DIVU; bus.src_a = 32'd100; bus.src_b = 32'd7;
    repeat (34) tick();
    bus.start = 1'b0;
    check("hold.strb", {30'd0, bus.hi_we, bus.lo_we}, 32'd3);
    check("hold.q",    bus.lo_o, 32'h0000000E);
    repeat (40) tick();
    check("hold.nhi", hi_strb - h0, 32'd1);
    check("hold.nlo", lo_strb - l0, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1);
  end

endmodule
